// File: rtl/io_map_pkg.sv
// io_map_pkg: shared I/O window address map. The CPU memory decoder imports
// the same constants, so any address change here moves both sides together.
package io_map_pkg;

  localparam int PORT_W = 32;

  localparam logic [7:0] ADDR_OUT0 = 8'h80;
  localparam logic [7:0] ADDR_OUT1 = 8'h84;
  localparam logic [7:0] ADDR_IN0  = 8'hC0;
  localparam logic [7:0] ADDR_IN1  = 8'hC4;
  localparam logic [7:0] ADDR_CHG  = 8'hC8;

  // Which register a read address selects.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_OUT0,
    SEL_OUT1,
    SEL_IN0,
    SEL_IN1,
    SEL_CHG
  } rd_sel_e;

  // Map a byte address to its read source; unmapped addresses read as zero.
  function automatic rd_sel_e decode_rd(input logic [7:0] addr);
    rd_sel_e sel;
    case (addr)
      ADDR_OUT0: sel = SEL_OUT0;
      ADDR_OUT1: sel = SEL_OUT1;
      ADDR_IN0:  sel = SEL_IN0;
      ADDR_IN1:  sel = SEL_IN1;
      ADDR_CHG:  sel = SEL_CHG;
      default:   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_in_sync.sv
// io_in_sync: 2-flop synchronizer for one 32-bit input port, optionally
// followed by a per-port debounce filter (macro IO_DEBOUNCE_EN).
// 'changed' pulses on the same cycle the 'stable' value takes a new value.
module io_in_sync
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [PORT_W-1:0] din,
  output logic [PORT_W-1:0] stable,
  output logic              changed
);

  // A zero-length debounce window has no meaning; reject it at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("io_in_sync: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [PORT_W-1:0] meta;
  logic [PORT_W-1:0] sync;

  // Two-stage synchronizer for the asynchronous external input.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]     cnt;
  logic [PORT_W-1:0] stable_q;
  logic              load;

  // cnt holds how many cycles beyond the first 'sync' has kept its value, so
  // reaching CNT_MAX with no pending change means DEBOUNCE_CYCLES held cycles.
  assign load = (cnt == CNT_MAX) && (meta == sync) && (sync != stable_q);

  // Restart the hold counter on any pending change, otherwise count up and
  // saturate; commit the synchronized value once it has been held long enough.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      stable_q <= '0;
    end else begin
      if (meta != sync) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        stable_q <= sync;
      end
    end
  end

  assign stable  = stable_q;
  assign changed = load;
`else
  // Without filtering the synchronizer output is the stable value; it changes
  // on the edge where the two stages currently disagree.
  assign stable  = sync;
  assign changed = (meta != sync);
`endif

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped I/O port block. Two registered output
// ports, two synchronized input ports with sticky change flags, and a
// registered read path.
// Handshake: a strobe (io_we / io_re) is a single-cycle request sampled on the
// rising edge; there is no back-pressure. Write data lands on that edge; read
// data is returned with io_rvalid=1 in the following cycle and io_rdata holds
// it afterwards. A combined read+write returns the pre-write contents.
// Optional feature: define IO_DEBOUNCE_EN to debounce the input ports.
module io_port_responder
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  io_addr,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [1:0]  in_change
);

  logic [31:0] stable0;
  logic [31:0] stable1;
  logic [1:0]  changed;
  logic [1:0]  chg_clr;
  logic [31:0] rd_mux;

  io_in_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync0 (
    .clock   (clock),
    .resetn  (resetn),
    .din     (in_port0),
    .stable  (stable0),
    .changed (changed[0])
  );

  io_in_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync1 (
    .clock   (clock),
    .resetn  (resetn),
    .din     (in_port1),
    .stable  (stable1),
    .changed (changed[1])
  );

  // Read source select, taken from current register contents (pre-write).
  always_comb begin
    rd_mux = '0;
    case (decode_rd(io_addr))
      SEL_OUT0: rd_mux = out_port0;
      SEL_OUT1: rd_mux = out_port1;
      SEL_IN0:  rd_mux = stable0;
      SEL_IN1:  rd_mux = stable1;
      SEL_CHG:  rd_mux = {30'b0, in_change};
      default:  rd_mux = '0;
    endcase
  end

  // Change-flag clears: reading a port's data, or write-1-to-clear at 0xC8.
  always_comb begin
    chg_clr = '0;
    if (io_re && (io_addr == ADDR_IN0)) chg_clr[0] = 1'b1;
    if (io_re && (io_addr == ADDR_IN1)) chg_clr[1] = 1'b1;
    if (io_we && (io_addr == ADDR_CHG)) chg_clr = chg_clr | io_wdata[1:0];
  end

  // Output port registers, written on the edge that samples io_we.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
    end else if (io_we) begin
      if (io_addr == ADDR_OUT0) out_port0 <= io_wdata;
      if (io_addr == ADDR_OUT1) out_port1 <= io_wdata;
    end
  end

  // Registered read response; reset drops any read already in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      io_rvalid <= 1'b0;
      io_rdata  <= '0;
    end else begin
      io_rvalid <= io_re;
      if (io_re) io_rdata <= rd_mux;
    end
  end

  // Sticky change flags; a new change in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_change <= '0;
    end else begin
      in_change <= changed | (in_change & ~chg_clr);
    end
  end

endmodule

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable cycles required before an input update (used only with IO_DEBOUNCE_EN).
REQ-002 The block SHALL have port clock, input, 1 bit, the single system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL have port io_addr, input, 8 bits, byte address within the I/O window.
REQ-005 The block SHALL have port io_we, input, 1 bit, write strobe.
REQ-006 The block SHALL have port io_re, input, 1 bit, read strobe.
REQ-007 The block SHALL have port io_wdata, input, 32 bits, write data.
REQ-008 The block SHALL have port io_rdata, output, 32 bits, registered read data.
REQ-009 The block SHALL have port io_rvalid, output, 1 bit, high for one cycle when io_rdata is valid.
REQ-010 The block SHALL have ports in_port0 and in_port1, input, 32 bits each, asynchronous external inputs.
REQ-011 The block SHALL have ports out_port0 and out_port1, output, 32 bits each, registered external outputs.
REQ-012 The block SHALL have port in_change, output, 2 bits, sticky change flags for in_port1 and in_port0.

Function
REQ-013 A write to 0x80 or 0x84 SHALL update out_port0 or out_port1 on the same rising edge that samples io_we; writes to any other address except 0xC8 SHALL be ignored.
REQ-014 A read SHALL drive io_rdata with io_rvalid=1 exactly one cycle after io_re is sampled; io_rvalid SHALL be 0 otherwise, and io_rdata SHALL hold its last value.
REQ-015 The read map SHALL be: 0x80/0x84 return out_port0/out_port1; 0xC0/0xC4 return stable in_port0/in_port1; 0xC8 returns {30'b0, in_change}; unmapped addresses return 0.
REQ-016 Each in_port bit SHALL pass through a 2-flop synchronizer before use.
REQ-017 Without debounce, the stable value SHALL equal the synchronizer output, visible to reads 2 cycles after the input changes.
REQ-018 in_change[n] SHALL set when the stable value of port n changes.
REQ-019 in_change[n] SHALL clear on a read of 0xC0+4n, or on a write to 0xC8 with io_wdata[n]=1 (write-1-to-clear).
REQ-020 If a set and a clear of in_change[n] fall in the same cycle, the set SHALL win.
REQ-021 When io_we and io_re are both asserted in one cycle, both SHALL be performed, and the read SHALL return the pre-write value.

Reset
REQ-022 resetn=0 SHALL asynchronously clear out_port0, out_port1, io_rdata, io_rvalid, in_change, synchronizer flops, stable values, and debounce counters to 0.
REQ-023 A read whose io_re was sampled before resetn asserted SHALL be dropped, with no io_rvalid after reset release.

Configuration
REQ-024 With macro IO_DEBOUNCE_EN defined, the stable value SHALL update only after the synchronized value has held an identical value for DEBOUNCE_CYCLES consecutive cycles; any change SHALL restart the per-port counter, which saturates.
REQ-025 Without IO_DEBOUNCE_EN, there SHALL be no counters, and REQ-017 timing SHALL apply.

Structure
REQ-026 The address constants (0x80, 0x84, 0xC0, 0xC4, 0xC8) SHALL reside in the shared package io_map_pkg, which the CPU memory decoder also uses.
REQ-027 The synchronizer and debounce logic SHALL be sub-module io_in_sync, instantiated once per input port.

Verification
REQ-028 Reset: with resetn=0 while io_re=1 at 0xC0 -> all outputs read 0, and no io_rvalid after release.
REQ-029 Write 0x0000_00A5 to 0x80, then read 0x80 -> out_port0=0xA5 after 1 edge; io_rdata=0xA5 with io_rvalid one cycle after io_re.
REQ-030 in_port1 0 -> 0x1234 (no debounce) -> read 0xC4 returns 0x1234 from cycle 2 onward; in_change=2'b10; read 0xC4 clears it to 2'b00.
REQ-031 With IO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: in_port0 toggles 0/1 every 5 cycles for 50 cycles then holds 1 -> stable value 0 throughout toggling; it becomes 1 exactly 2+16 cycles after the last edge.
REQ-032 Read 0xC0 in the same cycle a new stable change on port 0 arrives -> in_change[0] remains 1; write 0xC8 with 0x1 -> in_change[0]=0.
REQ-033 Simultaneous write 0x7 and read at 0x84 with prior value 0x3 -> io_rdata=0x3, out_port1=0x7; read of 0x90 returns 0.
